// File: rtl/alu_seq_datapath.sv
// ---------------------------------------------------------------------------
// alu_seq_datapath
//
// Registered ALU datapath with an internal register file. It accepts one
// operation per cycle over a valid/ready handshake. Operand A comes from
// rs1. Operand B comes from rs2 or the immediate. Each result is registered
// into ALUout, optionally written back to rd, and flagged by a one-cycle
// out_valid pulse. Register x0 is hardwired to zero.
//
// Optional feature macro: ALU_SEQ_MUL_EN
//   defined   : ALUControl 111 is an iterative shift-add multiply that takes
//               DATA_WIDTH cycles. The design holds in_ready low and busy high
//               while it runs.
//   undefined : ALUControl 111 is a single-cycle op with result 0.
//               in_ready is tied to 1 and busy is tied to 0.
//
// Ports:
//   clk            in   rising-edge clock
//   rst            in   asynchronous active-high reset
//   in_valid       in   operation present on the inputs
//   in_ready       out  operation can be accepted this cycle
//   ALUControl     in   operation select (ADD SUB AND OR XOR SLT SLL MUL)
//   ALUSrc         in   operand B select: 0 = reg[rs2], 1 = ImmOp
//   ImmOp          in   immediate operand
//   rs1, rs2, rd   in   source / destination register addresses
//   RegWrite       in   write the result to rd (writes to x0 are dropped)
//   ALUout         out  last completed result, registered
//   out_valid      out  one-cycle pulse marking a new ALUout
//   result_eq_zero out  registered (ALUout == 0)
//   a0             out  continuous view of register 10
//   busy           out  multi-cycle operation in progress
// ---------------------------------------------------------------------------
module alu_seq_datapath #(
  parameter int CONTROL_BITS  = 3,
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CONTROL_BITS-1:0]  ALUControl,
  input  logic                     ALUSrc,
  input  logic [DATA_WIDTH-1:0]    ImmOp,
  input  logic [ADDRESS_WIDTH-1:0] rs1,
  input  logic [ADDRESS_WIDTH-1:0] rs2,
  input  logic [ADDRESS_WIDTH-1:0] rd,
  input  logic                     RegWrite,
  output logic [DATA_WIDTH-1:0]    ALUout,
  output logic                     out_valid,
  output logic                     result_eq_zero,
  output logic [DATA_WIDTH-1:0]    a0,
  output logic                     busy
);

  localparam int SHIFT_BITS = $clog2(DATA_WIDTH);
  localparam int NUM_REGS   = 1 << ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] A0_INDEX = ADDRESS_WIDTH'(10);

  localparam logic [CONTROL_BITS-1:0] OP_ADD = CONTROL_BITS'(0);
  localparam logic [CONTROL_BITS-1:0] OP_SUB = CONTROL_BITS'(1);
  localparam logic [CONTROL_BITS-1:0] OP_AND = CONTROL_BITS'(2);
  localparam logic [CONTROL_BITS-1:0] OP_OR  = CONTROL_BITS'(3);
  localparam logic [CONTROL_BITS-1:0] OP_XOR = CONTROL_BITS'(4);
  localparam logic [CONTROL_BITS-1:0] OP_SLT = CONTROL_BITS'(5);
  localparam logic [CONTROL_BITS-1:0] OP_SLL = CONTROL_BITS'(6);
  localparam logic [CONTROL_BITS-1:0] OP_MUL = CONTROL_BITS'(7);

  logic [DATA_WIDTH-1:0]    r_regs [NUM_REGS];
  logic [DATA_WIDTH-1:0]    r_aluOut;
  logic                     r_outValid;
  logic                     r_eqZero;

  logic                     w_accept;
  logic [DATA_WIDTH-1:0]    w_opA;
  logic [DATA_WIDTH-1:0]    w_opB;
  logic [DATA_WIDTH-1:0]    w_aluResult;
  logic                     w_wrEn;
  logic [ADDRESS_WIDTH-1:0] w_wrAddr;
  logic [DATA_WIDTH-1:0]    w_wrData;

  assign w_accept = in_valid && in_ready;

  // Operand fetch. x0 reads as zero. A write landing on the same edge is
  // not visible until the following cycle, so a same-cycle read returns the
  // old value.
  assign w_opA = (rs1 == '0) ? '0 : r_regs[rs1];
  assign w_opB = ALUSrc ? ImmOp : ((rs2 == '0) ? '0 : r_regs[rs2]);

  assign a0             = r_regs[A0_INDEX];
  assign ALUout         = r_aluOut;
  assign out_valid      = r_outValid;
  assign result_eq_zero = r_eqZero;

  // Single-cycle ALU. MUL yields 0 here. When the iterative multiplier is
  // built, it produces its own result and never uses this value.
  always_comb begin
    w_aluResult = '0;
    case (ALUControl)
      OP_ADD:  w_aluResult = w_opA + w_opB;
      OP_SUB:  w_aluResult = w_opA - w_opB;
      OP_AND:  w_aluResult = w_opA & w_opB;
      OP_OR:   w_aluResult = w_opA | w_opB;
      OP_XOR:  w_aluResult = w_opA ^ w_opB;
      OP_SLT:  w_aluResult[0] = ($signed(w_opA) < $signed(w_opB));
      OP_SLL:  w_aluResult = w_opA << w_opB[SHIFT_BITS-1:0];
      OP_MUL:  w_aluResult = '0;
      default: w_aluResult = '0;
    endcase
  end

  // Register file with one write port. The x0 filter lives here, so no
  // writer needs to special-case rd == 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wrEn && (w_wrAddr != '0)) begin
      r_regs[w_wrAddr] <= w_wrData;
    end
  end

`ifdef ALU_SEQ_MUL_EN

  localparam int COUNT_BITS = (SHIFT_BITS + 1 > 6) ? (SHIFT_BITS + 1) : 6;

  typedef enum logic {
    ST_IDLE,
    ST_MULB
  } state_t;

  state_t                   r_state;
  logic [COUNT_BITS-1:0]    r_count;
  logic [DATA_WIDTH-1:0]    r_mulA;
  logic [DATA_WIDTH-1:0]    r_mulB;
  logic [DATA_WIDTH-1:0]    r_mulAcc;
  logic [ADDRESS_WIDTH-1:0] r_mulRd;
  logic                     r_mulWrite;
  logic                     r_inReady;
  logic                     r_busy;

  logic                     w_isMul;
  logic [DATA_WIDTH-1:0]    w_mulSum;
  logic                     w_mulDone;

  assign w_isMul   = (ALUControl == OP_MUL);
  assign w_mulSum  = r_mulAcc + (r_mulB[0] ? r_mulA : '0);
  assign w_mulDone = (r_state == ST_MULB) && (r_count == '0);
  assign in_ready  = r_inReady;
  assign busy      = r_busy;

  // Write-port steering. The multiplier's final step and a single-cycle
  // accept can never coincide, because in_ready is low during MULB.
  always_comb begin
    w_wrEn   = 1'b0;
    w_wrAddr = rd;
    w_wrData = w_aluResult;
    if (w_mulDone) begin
      w_wrEn   = r_mulWrite;
      w_wrAddr = r_mulRd;
      w_wrData = w_mulSum;
    end else if (w_accept && !w_isMul) begin
      w_wrEn   = RegWrite;
    end
  end

  // Control FSM and registered outputs. A MUL loads the operands and then
  // runs DATA_WIDTH shift-add steps, one per edge. The count runs from
  // DATA_WIDTH-1 to 0. The step taken at count 0 also retires the result,
  // so it lands exactly DATA_WIDTH edges after the accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_mulA     <= '0;
      r_mulB     <= '0;
      r_mulAcc   <= '0;
      r_mulRd    <= '0;
      r_mulWrite <= 1'b0;
      r_inReady  <= 1'b1;
      r_busy     <= 1'b0;
      r_aluOut   <= '0;
      r_eqZero   <= 1'b1;
      r_outValid <= 1'b0;
    end else begin
      r_outValid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_isMul) begin
              r_mulA     <= w_opA;
              r_mulB     <= w_opB;
              r_mulAcc   <= '0;
              r_mulRd    <= rd;
              r_mulWrite <= RegWrite;
              r_count    <= COUNT_BITS'(DATA_WIDTH - 1);
              r_inReady  <= 1'b0;
              r_busy     <= 1'b1;
              r_state    <= ST_MULB;
            end else begin
              r_aluOut   <= w_aluResult;
              r_eqZero   <= (w_aluResult == '0);
              r_outValid <= 1'b1;
            end
          end
        end
        ST_MULB: begin
          r_mulAcc <= w_mulSum;
          r_mulA   <= r_mulA << 1;
          r_mulB   <= r_mulB >> 1;
          if (r_count == '0) begin
            r_aluOut   <= w_mulSum;
            r_eqZero   <= (w_mulSum == '0);
            r_outValid <= 1'b1;
            r_inReady  <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= ST_IDLE;
          end else begin
            r_count <= r_count - 1'b1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_inReady <= 1'b1;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

`else

  assign in_ready = 1'b1;
  assign busy     = 1'b0;

  // Every operation, including MUL, completes at its accept edge.
  always_comb begin
    w_wrEn   = w_accept && RegWrite;
    w_wrAddr = rd;
    w_wrData = w_aluResult;
  end

  // Result register and one-cycle completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aluOut   <= '0;
      r_eqZero   <= 1'b1;
      r_outValid <= 1'b0;
    end else begin
      r_outValid <= w_accept;
      if (w_accept) begin
        r_aluOut <= w_aluResult;
        r_eqZero <= (w_aluResult == '0);
      end
    end
  end

`endif

endmodule

// File: tb/tb_alu_seq_datapath.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_datapath
//
// Drives directed and random operations into alu_seq_datapath. It compares
// every completion against a register-array reference model that evaluates
// the operations with plain arithmetic. Build it with or without
// ALU_SEQ_MUL_EN; the MUL expectations follow the same macro.
// ---------------------------------------------------------------------------
module tb_alu_seq_datapath;

  localparam int DW = 32;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  ALUControl;
  logic        ALUSrc;
  logic [31:0] ImmOp;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        RegWrite;
  logic [31:0] ALUout;
  logic        out_valid;
  logic        result_eq_zero;
  logic [31:0] a0;
  logic        busy;

  int          compareCount = 0;
  int          failCount    = 0;
  logic [31:0] modelRegs [32];

  alu_seq_datapath #(
    .CONTROL_BITS (3),
    .DATA_WIDTH   (DW),
    .ADDRESS_WIDTH(5)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .ALUControl    (ALUControl),
    .ALUSrc        (ALUSrc),
    .ImmOp         (ImmOp),
    .rs1           (rs1),
    .rs2           (rs2),
    .rd            (rd),
    .RegWrite      (RegWrite),
    .ALUout        (ALUout),
    .out_valid     (out_valid),
    .result_eq_zero(result_eq_zero),
    .a0            (a0),
    .busy          (busy)
  );

  // Free-running 10-time-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net in case some wait is never satisfied
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference semantics of each ALUControl code
  function automatic logic [31:0] modelAlu(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: return a << (b % 32);
`ifdef ALU_SEQ_MUL_EN
      default: return a * b;
`else
      default: return 32'd0;
`endif
    endcase
  endfunction

  // Single comparison point; counts and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < 32; i++) modelRegs[i] = 32'd0;
  endtask

  // Issues one op, waits for its completion pulse, and checks latency, the
  // ready-low window, the result, the zero flag and a0. With compete set, a
  // different op is held on the inputs while the first one runs.
  task automatic applyStimulus(input string tag, input logic [2:0] op, input logic src,
                               input logic [31:0] imm, input logic [4:0] r1,
                               input logic [4:0] r2, input logic [4:0] d,
                               input logic we, input logic compete);
    logic [31:0] opA;
    logic [31:0] opB;
    logic [31:0] expected;
    int          expLatency;
    int          expLow;
    int          waits;
    int          latency;
    int          lowCycles;
    bit          done;
    opA = modelRegs[r1];
    opB = src ? imm : modelRegs[r2];
    expected = modelAlu(op, opA, opB);
    expLatency = 1;
    expLow = 0;
`ifdef ALU_SEQ_MUL_EN
    if (op == 3'd7) begin
      expLatency = DW + 1;
      expLow = DW;
    end
`endif
    @(negedge clk);
    ALUControl = op; ALUSrc = src; ImmOp = imm;
    rs1 = r1; rs2 = r2; rd = d; RegWrite = we; in_valid = 1'b1;
    waits = 0;
    while (in_ready !== 1'b1 && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    checkOutput({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    if (compete) begin
      ALUControl = 3'd0; ALUSrc = 1'b1; ImmOp = 32'd99;
      rs1 = 5'd0; rd = 5'd5; RegWrite = 1'b1; in_valid = 1'b1;
    end else begin
      in_valid = 1'b0;
    end
    latency = 0;
    lowCycles = 0;
    done = 1'b0;
    while (!done && latency < 100) begin
      @(negedge clk);
      latency++;
      if (in_ready === 1'b0) lowCycles++;
      if (out_valid === 1'b1) done = 1'b1;
    end
    in_valid = 1'b0;
    if (we && d != 5'd0) modelRegs[d] = expected;
    checkOutput({tag, "_latency"}, 32'(latency), 32'(expLatency));
    checkOutput({tag, "_readyLow"}, 32'(lowCycles), 32'(expLow));
    checkOutput({tag, "_result"}, ALUout, expected);
    checkOutput({tag, "_eqZero"}, {31'd0, result_eq_zero}, {31'd0, expected == 32'd0});
    checkOutput({tag, "_a0"}, a0, modelRegs[10]);
  endtask

  initial begin
    int pulses;
    logic [2:0]  rOp;
    logic [31:0] rImm;

    clearModel();
    rst = 1'b1;
    in_valid = 1'b0; ALUControl = 3'd0; ALUSrc = 1'b0; ImmOp = 32'd0;
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; RegWrite = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    checkOutput("reset_aluout", ALUout, 32'd0);
    checkOutput("reset_eqzero", {31'd0, result_eq_zero}, 32'd1);
    checkOutput("reset_outvalid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_a0", a0, 32'd0);

    // Back-to-back dependent ops: ADD x10 = x0 + 5, then SUB x10 = x10 - 5
    @(negedge clk);
    ALUControl = 3'd0; ALUSrc = 1'b1; ImmOp = 32'd5;
    rs1 = 5'd0; rd = 5'd10; RegWrite = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    ALUControl = 3'd1; rs1 = 5'd10;
    @(negedge clk);
    checkOutput("b2b_add_result", ALUout, 32'd5);
    checkOutput("b2b_add_a0", a0, 32'd5);
    checkOutput("b2b_add_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    checkOutput("b2b_sub_result", ALUout, 32'd0);
    checkOutput("b2b_sub_a0", a0, 32'd0);
    checkOutput("b2b_sub_eqzero", {31'd0, result_eq_zero}, 32'd1);
    checkOutput("b2b_sub_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    checkOutput("pulse_single_cycle", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset pulse in mid-cycle clears the register file
    applyStimulus("seed_a0", 3'd0, 1'b1, 32'd5, 5'd0, 5'd0, 5'd10, 1'b1, 1'b0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("async_rst_a0", a0, 32'd0);
    checkOutput("async_rst_aluout", ALUout, 32'd0);
    checkOutput("async_rst_eqzero", {31'd0, result_eq_zero}, 32'd1);
    checkOutput("async_rst_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("async_rst_outvalid", {31'd0, out_valid}, 32'd0);
    #1 rst = 1'b0;
    clearModel();

    // x0 is hardwired: the write is dropped but ALUout still shows it
    applyStimulus("x0_write", 3'd0, 1'b1, 32'd7, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    checkOutput("x0_write_out", ALUout, 32'd7);
    applyStimulus("x0_read", 3'd0, 1'b0, 32'd0, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0);
    checkOutput("x0_read_out", ALUout, 32'd0);

    // SLT, SLL with a masked shift amount, XOR
    applyStimulus("ld_neg1", 3'd0, 1'b1, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0);
    applyStimulus("slt", 3'd5, 1'b1, 32'd1, 5'd2, 5'd0, 5'd3, 1'b1, 1'b0);
    checkOutput("slt_const", ALUout, 32'd1);
    applyStimulus("ld_one", 3'd0, 1'b1, 32'd1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0);
    applyStimulus("sll", 3'd6, 1'b1, 32'h21, 5'd4, 5'd0, 5'd5, 1'b1, 1'b0);
    checkOutput("sll_const", ALUout, 32'd2);
    applyStimulus("ld_f0f0", 3'd0, 1'b1, 32'hF0F0, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0);
    applyStimulus("xor", 3'd4, 1'b1, 32'hFFFF, 5'd6, 5'd0, 5'd7, 1'b1, 1'b0);
    checkOutput("xor_const", ALUout, 32'h0F0F);

    // MUL while a competing op is held on the inputs
    applyStimulus("ld_10001", 3'd0, 1'b1, 32'h10001, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0);
    applyStimulus("mul", 3'd7, 1'b1, 32'h10001, 5'd8, 5'd0, 5'd9, 1'b1, 1'b1);
`ifdef ALU_SEQ_MUL_EN
    checkOutput("mul_const", ALUout, 32'h0002_0001);
`else
    checkOutput("mul_const", ALUout, 32'd0);
`endif
    applyStimulus("compete_not_taken", 3'd0, 1'b1, 32'd0, 5'd5, 5'd0, 5'd11, 1'b1, 1'b0);
    checkOutput("compete_x5", ALUout, 32'd2);

    // Reset during a multiply: nothing retires, the next op goes straight in
    @(negedge clk);
    ALUControl = 3'd7; ALUSrc = 1'b1; ImmOp = 32'd3;
    rs1 = 5'd8; rd = 5'd9; RegWrite = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("mulrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("mulrst_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("mulrst_outvalid", {31'd0, out_valid}, 32'd0);
    checkOutput("mulrst_aluout", ALUout, 32'd0);
    #1 rst = 1'b0;
    clearModel();
    ALUControl = 3'd0; ALUSrc = 1'b0; rs1 = 5'd9; rs2 = 5'd0;
    rd = 5'd1; RegWrite = 1'b1; in_valid = 1'b1;
    checkOutput("mulrst_next_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    checkOutput("mulrst_next_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("mulrst_x9_cleared", ALUout, 32'd0);
    pulses = 0;
    for (int k = 0; k < DW + 4; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) pulses++;
    end
    checkOutput("mulrst_no_late_pulse", 32'(pulses), 32'd0);

    // Random operations against the model
    for (int i = 0; i < 40; i++) begin
      rOp = 3'($urandom_range(0, 7));
      rImm = $urandom;
      if ($urandom_range(0, 3) == 0) rImm = 32'($urandom_range(0, 40));
      applyStimulus($sformatf("rand%0d", i), rOp, 1'($urandom_range(0, 1)), rImm,
                    5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                    5'($urandom_range(0, 31)), 1'($urandom_range(0, 3) != 0), 1'b0);
    end

    // Every model register matches the DUT when read back through ADD
    for (int r = 1; r < 32; r++) begin
      applyStimulus($sformatf("final_x%0d", r), 3'd0, 1'b1, 32'd0, 5'(r), 5'd0,
                    5'd0, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule

// File: doc/alu_seq_datapath.md
# alu_seq_datapath

Parametrised, registered successor to the single-cycle register-file/ALU test datapath. It accepts one operation per cycle over a valid/ready handshake and reads operands from an internal register file, with operand 2 selected between rs2 and an immediate. Each result is registered, written back and flagged with a one-cycle `out_valid` pulse. It adds reset, a hardwired-zero x0, XOR/SLT/SLL operations and an optional iterative multi-cycle multiplier. It is the execution core used by the lab-level CPU bring-up benches.

## Interface
- `CONTROL_BITS`, 3: ALUControl width. Fixed at 3; other values unsupported.
- `DATA_WIDTH`, 32: datapath width. Must be a power of two, ≥ 8.
- `ADDRESS_WIDTH`, 5: register address width; the file holds 2^ADDRESS_WIDTH registers.

Ports:
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: operation present on the inputs.
- `in_ready`  out  1: operation can be accepted this cycle.
- `ALUControl`  in  CONTROL_BITS: operation select.
- `ALUSrc`  in  1: operand 2 select; 0 = rs2 register, 1 = `ImmOp`.
- `ImmOp`  in  DATA_WIDTH: immediate operand.
- `rs1`, `rs2`, `rd`  in  ADDRESS_WIDTH: source and destination addresses.
- `RegWrite`  in  1: write the result to `rd`.
- `ALUout`  out  DATA_WIDTH: last completed result, registered.
- `out_valid`  out  1: one-cycle pulse marking a new `ALUout`.
- `result_eq_zero`  out  1: registered flag, (`ALUout` == 0).
- `a0`  out  DATA_WIDTH: continuous view of register 10.
- `busy`  out  1: a multi-cycle operation is in progress.

## Operation
- Accept = `in_valid && in_ready`. Inputs are sampled only on accept.
- Operand A = reg[`rs1`]. Operand B = `ALUSrc` ? `ImmOp` : reg[`rs2`]. Register 0 always reads 0.
- ALUControl encoding:
  - 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR.
  - 101 SLT: signed compare; result 1 or 0, zero-extended.
  - 110 SLL: shift A left by B[$clog2(DATA_WIDTH)-1:0].
  - 111 MUL: see Configuration.
- All arithmetic is modulo 2^DATA_WIDTH. Overflow and carry are discarded.
- Writeback: when `RegWrite`=1 and `rd`≠0, reg[`rd`] takes the result at the completing edge. Writes to x0 are dropped. `ALUout` and `out_valid` update regardless of `RegWrite`.
- State machine:
  - IDLE: `in_ready`=1. Single-cycle ops complete at the accept edge. MUL moves to MULB at the accept edge.
  - MULB: `in_ready`=0, `busy`=1. The 6-bit (≥ $clog2(DATA_WIDTH)+1) counter decrements each edge. When the counter expires, the result is written, `out_valid` is set and the FSM returns to IDLE.
- No output backpressure. `out_valid` is a pulse; the consumer must sample it.

## Timing
- Reset values:
  - `ALUout`=0, `result_eq_zero`=1, `out_valid`=0, `busy`=0, `in_ready`=1 (IDLE).
  - All registers 0, so `a0`=0.
- Single-cycle op accepted at edge N: `ALUout`, `result_eq_zero` and the register write update at edge N. `out_valid`=1 for the cycle after N only.
- Back-to-back dependent ops need no stall. A read in cycle N+1 sees the value written at edge N.
- A read and a write to the same register in the same cycle: the read returns the old value.
- MUL accepted at edge N: result at edge N+DATA_WIDTH.
  - `in_ready`=0 and `busy`=1 during cycles N+1 … N+DATA_WIDTH.
  - `out_valid` and `in_ready` are both 1 in cycle N+DATA_WIDTH+1.
- `in_valid` while `in_ready`=0 is ignored. The source must hold it until accepted.
- `rst` mid-MUL aborts immediately: no register write, no `out_valid`, all outputs at reset values.

## Configuration
- Macro `ALU_SEQ_MUL_EN`.
- Defined: code 111 is an iterative shift-add multiply over DATA_WIDTH cycles and produces the low DATA_WIDTH bits of A×B, with the unsigned/signed-agnostic low half. The MULB state and counter are present.
- Undefined: code 111 is a single-cycle op with result 0, written back normally. The MULB state is not generated, `busy` is tied to 0 and `in_ready` is tied to 1.

## Test plan
- Reset with `rst` pulsed mid-cycle (asynchronous) → `ALUout`=0, `result_eq_zero`=1, `a0`=0, `in_ready`=1, `out_valid`=0.
- ADD x10 = x0 + imm 5, then SUB x10 = x10 − imm 5 on consecutive cycles → `a0`=5, then 0. `result_eq_zero`=1 after the second op. `out_valid` high both following cycles.
- Write imm 7 to rd=0, then read x0 via ADD x1 = x0 + x0 → `ALUout`=0, x0 stays 0.
- SLT with A=0xFFFFFFFF, B=1 → 1. SLL with A=1, B=0x21 → 2 (shift amount masked to 1). XOR 0xF0F0 ^ 0xFFFF → 0x0F0F.
- With `ALU_SEQ_MUL_EN` defined: MUL 0x10001 × 0x10001 → 0x00020001 after 32 cycles. `in_ready` is low for exactly 32 cycles, and a competing `in_valid` during that window is not accepted. Without the macro, the same op gives 0 in 1 cycle.
- MUL with `rst` asserted at cycle 10 of the multiply → the destination register is unchanged, no `out_valid` pulse, and a subsequent ADD is accepted in the first cycle after reset.
